// File: rtl/fsk_pkg.sv
// Shared types and default constants for the binary-FSK transmitter.
package fsk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsk_state_t;

    localparam int CODE_W_DEF     = 14;
    localparam int BIT_CYCLES_DEF = 16;
    localparam int MARK_DIV_DEF   = 1;
    localparam int SPACE_DIV_DEF  = 2;

endpackage

// File: rtl/fsk_tone_gen.sv
// Square-wave tone generator: toggles fsk every MARK_DIV or SPACE_DIV cycles.
// Phase is continuous across bits; only a disable (en low) forces fsk to 0.
module fsk_tone_gen
    import fsk_pkg::*;
#(
    parameter int MARK_DIV  = MARK_DIV_DEF,
    parameter int SPACE_DIV = SPACE_DIV_DEF
) (
    input  logic clk2,
    input  logic reset,
    input  logic en,
    input  logic sel_mark,
    input  logic restart,
    output logic fsk
);

    localparam int MAX_DIV = (MARK_DIV > SPACE_DIV) ? MARK_DIV : SPACE_DIV;
    localparam int TONE_W  = $clog2(MAX_DIV + 1);

    logic [TONE_W-1:0] tone_cnt;
    logic [TONE_W-1:0] div_m1;
    logic              wrap;

    // Pick the half-period of the tone for the current bit value
    always_comb begin
        div_m1 = sel_mark ? TONE_W'(MARK_DIV - 1) : TONE_W'(SPACE_DIV - 1);
        wrap   = (tone_cnt == div_m1);
    end

    // Half-period counter and output flop; restart realigns the counter at bit boundaries
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            tone_cnt <= '0;
            fsk      <= 1'b0;
        end else if (!en) begin
            tone_cnt <= '0;
            fsk      <= 1'b0;
        end else begin
            if (wrap)
                fsk <= ~fsk;
            if (wrap || restart)
                tone_cnt <= '0;
            else
                tone_cnt <= tone_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fsk_modulator_param.sv
// Parametrised binary-FSK transmitter: accepts a codeword on a valid/ready
// handshake and sends it LSB first, BIT_CYCLES clk2 cycles per bit.
// Optional macro FSK_CONT_EN: with no new word at frame end, the last
// codeword is re-transmitted continuously until reset.
module fsk_modulator_param
    import fsk_pkg::*;
#(
    parameter int CODE_W     = CODE_W_DEF,
    parameter int BIT_CYCLES = BIT_CYCLES_DEF,
    parameter int MARK_DIV   = MARK_DIV_DEF,
    parameter int SPACE_DIV  = SPACE_DIV_DEF
) (
    input  logic                      clk2,
    input  logic                      reset,
    input  logic [CODE_W-1:0]         code_in,
    input  logic                      code_valid,
    output logic                      code_ready,
    output logic                      fsk,
    output logic                      busy,
    output logic [$clog2(CODE_W)-1:0] bit_idx,
    output logic                      frame_done
);

    localparam int BIT_W = $clog2(CODE_W);
    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    fsk_state_t        state;
    fsk_state_t        state_next;
    logic [CODE_W-1:0] shift_reg;
    logic [CYC_W-1:0]  cyc_cnt;
    logic              bit_end;
    logic              frame_end;
    logic              accept;
    logic              tone_en;

    // Handshake, frame boundaries and next-state decision
    always_comb begin
        bit_end    = (state == SEND) && (cyc_cnt == CYC_W'(BIT_CYCLES - 1));
        frame_end  = bit_end && (bit_idx == BIT_W'(CODE_W - 1));
        frame_done = frame_end;
        code_ready = (state == IDLE) || frame_end;
        busy       = (state == SEND);
        accept     = code_valid && code_ready;
        tone_en    = (state == SEND);
        state_next = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_next = SEND;
            end
            SEND: begin
                if (frame_end && !code_valid) begin
`ifdef FSK_CONT_EN
                    state_next = SEND;
`else
                    // Dropping the tone enable clears fsk on the same edge we go idle
                    state_next = IDLE;
                    tone_en    = 1'b0;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Cycle-in-bit and bit-index counters; both restart on every accepted word
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            cyc_cnt <= '0;
            bit_idx <= '0;
        end else if (accept) begin
            cyc_cnt <= '0;
            bit_idx <= '0;
        end else if (state == SEND) begin
            if (bit_end) begin
                cyc_cnt <= '0;
                bit_idx <= frame_end ? '0 : bit_idx + 1'b1;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    // Codeword capture; data path carries no reset
    always_ff @(posedge clk2) begin
        if (accept)
            shift_reg <= code_in;
    end

    fsk_tone_gen #(
        .MARK_DIV  (MARK_DIV),
        .SPACE_DIV (SPACE_DIV)
    ) u_tone (
        .clk2     (clk2),
        .reset    (reset),
        .en       (tone_en),
        .sel_mark (shift_reg[bit_idx]),
        .restart  (bit_end),
        .fsk      (fsk)
    );

endmodule

// File: tb/tb_fsk_modulator_param.sv
// Self-checking bench for fsk_modulator_param (default parameters).
// Optional macro FSK_CONT_EN selects the continuous re-transmission scenario.
module tb_fsk_modulator_param;

    localparam int CW    = 14;
    localparam int BC    = 16;
    localparam int MD    = 1;
    localparam int SD    = 2;
    localparam int FRAME = CW * BC;

    logic          clk2;
    logic          reset;
    logic [CW-1:0] code_in;
    logic          code_valid;
    logic          code_ready;
    logic          fsk;
    logic          busy;
    logic [3:0]    bit_idx;
    logic          frame_done;

    int total = 0;
    int bad   = 0;
    logic [CW-1:0] wq [4];

    fsk_modulator_param #(
        .CODE_W     (CW),
        .BIT_CYCLES (BC),
        .MARK_DIV   (MD),
        .SPACE_DIV  (SD)
    ) dut (
        .clk2       (clk2),
        .reset      (reset),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .fsk        (fsk),
        .busy       (busy),
        .bit_idx    (bit_idx),
        .frame_done (frame_done)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    // Sends nw frames from wq starting from IDLE; entry/exit just after a posedge.
    // The reference tracks the tone phase from the bit rules: within a bit,
    // the output flips after every div-th cycle, and phase carries across bits.
    task automatic run_seq(input int nw, input bit hold_valid, input bit cont, output int toggles);
        logic       fsk_ref;
        logic       prev;
        logic [7:0] got;
        logic [7:0] exp;
        int b, c, dv;
        fsk_ref = 1'b0;
        toggles = 0;
        prev    = 1'b0;
        code_valid = 1'b1;
        code_in    = wq[0];
        @(negedge clk2);
        total++;
        if ({busy, code_ready} !== 2'b01) begin
            bad++;
            $display("FAIL pre_accept got busy/ready=%b exp=01", {busy, code_ready});
        end
        @(posedge clk2); #1;
        for (int f = 0; f < nw; f++) begin
            for (int k = 0; k < FRAME; k++) begin
                if (k == FRAME - 1) begin
                    if (!cont && f < nw - 1) begin
                        code_valid = 1'b1;
                        code_in    = wq[f + 1];
                    end else begin
                        code_valid = 1'b0;
                        code_in    = CW'($urandom);
                    end
                end else begin
                    code_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
                    code_in    = CW'($urandom);
                end
                @(negedge clk2);
                b = k / BC;
                c = k % BC;
                got = {busy, bit_idx, frame_done, code_ready, fsk};
                exp = {1'b1, 4'(b), (k == FRAME - 1), (k == FRAME - 1), fsk_ref};
                total++;
                if (got !== exp) begin
                    bad++;
                    if (bad < 20)
                        $display("FAIL send f=%0d k=%0d got=%b exp=%b", f, k, got, exp);
                end
                if (fsk !== prev) toggles++;
                prev = fsk;
                dv = wq[f][b] ? MD : SD;
                if ((c + 1) % dv == 0) fsk_ref = ~fsk_ref;
                if (k == FRAME - 1 && f == nw - 1 && !cont) fsk_ref = 1'b0;
                @(posedge clk2); #1;
            end
        end
        code_valid = 1'b0;
        if (!cont) begin
            @(negedge clk2);
            if (fsk !== prev) toggles++;
            total++;
            if ({busy, frame_done, code_ready, fsk} !== 4'b0010) begin
                bad++;
                $display("FAIL idle_after got busy/done/ready/fsk=%b exp=0010",
                         {busy, frame_done, code_ready, fsk});
            end
            @(posedge clk2); #1;
        end else begin
            reset = 1'b1;
            @(negedge clk2);
            reset = 1'b0;
            @(posedge clk2); #1;
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({fsk, busy, code_ready, frame_done, bit_idx} !== 8'b0010_0000) begin
            bad++;
            $display("FAIL reset_state got=%b exp=00100000", {fsk, busy, code_ready, frame_done, bit_idx});
        end
        repeat (2) @(posedge clk2);
        #1;
        total++;
        if ({fsk, busy, code_ready, frame_done, bit_idx} !== 8'b0010_0000) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=00100000", {fsk, busy, code_ready, frame_done, bit_idx});
        end
        @(negedge clk2);
        reset = 1'b0;
        @(posedge clk2); #1;
    endtask

    task automatic test_tones();
        int tg;
        wq[0] = 14'h3FFF;
        run_seq(1, 1'b0, 1'b0, tg);
        total++;
        if (tg !== 224) begin
            bad++;
            $display("FAIL mark_toggles got=%0d exp=224", tg);
        end
        wq[0] = 14'h0000;
        run_seq(1, 1'b0, 1'b0, tg);
        total++;
        if (tg !== 112) begin
            bad++;
            $display("FAIL space_toggles got=%0d exp=112", tg);
        end
        wq[0] = 14'h0001;
        run_seq(1, 1'b0, 1'b0, tg);
    endtask

    task automatic test_reset_midframe();
        int tg;
        code_valid = 1'b1;
        code_in    = 14'h1234;
        @(posedge clk2); #1;
        code_valid = 1'b0;
        repeat (5 * BC + 3) @(posedge clk2);
        #1;
        total++;
        if ({busy, bit_idx} !== {1'b1, 4'd5}) begin
            bad++;
            $display("FAIL mid_bit got busy/bit=%b exp=10101", {busy, bit_idx});
        end
        reset = 1'b1;
        #1;
        total++;
        if ({fsk, busy, code_ready, bit_idx} !== 7'b0010000) begin
            bad++;
            $display("FAIL mid_reset got=%b exp=0010000", {fsk, busy, code_ready, bit_idx});
        end
        @(negedge clk2);
        reset = 1'b0;
        @(posedge clk2); #1;
        wq[0] = 14'h2C5A;
        run_seq(1, 1'b0, 1'b0, tg);
    endtask

    task automatic test_back_to_back();
        int tg;
        wq[0] = 14'h2AAA;
        wq[1] = 14'h1555;
        run_seq(2, 1'b1, 1'b0, tg);
    endtask

    task automatic test_random();
        int tg;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) wq[j] = CW'($urandom);
            run_seq($urandom_range(1, 2), 1'b0, 1'b0, tg);
        end
    endtask

    task automatic test_cont();
        int tg;
        for (int j = 0; j < 3; j++) wq[j] = 14'h0F0F;
        run_seq(3, 1'b0, 1'b1, tg);
    endtask

    initial begin
        reset      = 1'b1;
        code_valid = 1'b0;
        code_in    = '0;
        test_reset();
`ifdef FSK_CONT_EN
        test_cont();
`else
        test_tones();
        test_reset_midframe();
        test_back_to_back();
        test_random();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
